// File: rtl/wb_cfg_pkg.sv
// Shared types and constants for the Wishbone config responder.
package wb_cfg_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    ACK  = 2'd2
  } wb_state_e;

  localparam int WB_SEL_W = 4;
  localparam int IRQ_BIT  = 0;

  function automatic int log2_f(input int n);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++)
      if ((1 << i) < n) r = i + 1;
    return r;
  endfunction

endpackage

// File: rtl/wb_cfg_regbank.sv
// Byte-enabled register array; the top register is a read-only count of acked writes.
module wb_cfg_regbank
  import wb_cfg_pkg::*;
#(
  parameter int NUM_REGS = 8,
  parameter int IDX_W    = 3
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     wr_en,
  input  logic                     cnt_inc,
  input  logic [IDX_W-1:0]         idx,
  input  logic [WB_SEL_W-1:0]      sel,
  input  logic [31:0]              wdata,
  output logic [32*NUM_REGS-1:0]   regs_flat,
  output logic [31:0]              rd_data
);

  logic [NUM_REGS-1:0][31:0] regs_q, regs_d;

  always_comb begin
    regs_d = regs_q;
    if (wr_en && (idx != IDX_W'(NUM_REGS - 1))) begin
      for (int b = 0; b < WB_SEL_W; b++)
        if (sel[b]) regs_d[idx][8*b +: 8] = wdata[8*b +: 8];
    end
    // Counter wraps naturally at 32 bits.
    if (cnt_inc) regs_d[NUM_REGS-1] = regs_q[NUM_REGS-1] + 32'd1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) regs_q <= '0;
    else     regs_q <= regs_d;
  end

  assign regs_flat = regs_q;
  assign rd_data   = regs_q[idx];

endmodule

// File: rtl/wb_cfg_responder.sv
// Wishbone classic config slave: window decode, wait-state FSM, register bank, irq pulse.
// Optional WB_CFG_ERR_EN: adds wbs_err, which terminates decode misses instead of wbs_ack.
module wb_cfg_responder
  import wb_cfg_pkg::*;
#(
  parameter logic [31:0] pADDR_BASE   = 32'h3000_3000,
  parameter logic [31:0] pADDR_MASK   = 32'hFFFF_FFE0,
  parameter int          pNUM_REGS    = 8,
  parameter int          pWAIT_CYCLES = 2
) (
  input  logic                      wb_clk,
  input  logic                      wb_rst,
  input  logic [31:0]               wbs_adr,
  input  logic [31:0]               wbs_wdata,
  input  logic [WB_SEL_W-1:0]       wbs_sel,
  input  logic                      wbs_cyc,
  input  logic                      wbs_stb,
  input  logic                      wbs_we,
  output logic                      wbs_ack,
`ifdef WB_CFG_ERR_EN
  output logic                      wbs_err,
`endif
  output logic [31:0]               wbs_rdata,
  output logic [32*pNUM_REGS-1:0]   cfg_out,
  output logic                      irq_o
);

  localparam int IDX_W = log2_f(pNUM_REGS);
`ifdef WB_CFG_ERR_EN
  localparam bit ERR_EN = 1'b1;
`else
  localparam bit ERR_EN = 1'b0;
`endif

  wb_state_e             state_q, state_d;
  logic [3:0]            cnt_q, cnt_d;
  logic [31:0]           adr_q, adr_d;
  logic [31:0]           wdata_q, wdata_d;
  logic [WB_SEL_W-1:0]   sel_q, sel_d;
  logic                  we_q, we_d;
  logic                  ack_q, ack_d;
  logic                  err_q, err_d;
  logic [31:0]           rdata_q, rdata_d;
  logic                  irq_q, irq_d;

  logic                  hit;
  logic [IDX_W-1:0]      idx;
  logic [31:0]           rd_data;
  logic                  commit;

  assign hit    = ((adr_q & pADDR_MASK) == pADDR_BASE);
  assign idx    = adr_q[2 +: IDX_W];
  assign commit = (state_q == ACK);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    adr_d   = adr_q;
    wdata_d = wdata_q;
    sel_d   = sel_q;
    we_d    = we_q;
    ack_d   = 1'b0;
    err_d   = 1'b0;
    rdata_d = '0;
    irq_d   = 1'b0;
    case (state_q)
      IDLE: begin
        if (wbs_cyc && wbs_stb) begin
          adr_d   = wbs_adr;
          wdata_d = wbs_wdata;
          sel_d   = wbs_sel;
          we_d    = wbs_we;
          cnt_d   = 4'(pWAIT_CYCLES);
          state_d = (pWAIT_CYCLES == 0) ? ACK : WAIT;
        end
      end
      WAIT: begin
        if (!(wbs_cyc && wbs_stb)) state_d = IDLE;
        else if (cnt_q <= 4'd1) begin
          cnt_d   = '0;
          state_d = ACK;
        end else cnt_d = cnt_q - 4'd1;
      end
      ACK: begin
        // Leaving ACK is the edge that raises the response and commits the write.
        state_d = IDLE;
        if (hit || !ERR_EN) ack_d = 1'b1;
        else                err_d = 1'b1;
        if (!we_q && hit) rdata_d = rd_data;
        irq_d = we_q && hit && (idx == '0) && sel_q[IRQ_BIT/8] && wdata_q[IRQ_BIT];
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge wb_clk or posedge wb_rst) begin
    if (wb_rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      adr_q   <= '0;
      wdata_q <= '0;
      sel_q   <= '0;
      we_q    <= 1'b0;
      ack_q   <= 1'b0;
      err_q   <= 1'b0;
      rdata_q <= '0;
      irq_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      adr_q   <= adr_d;
      wdata_q <= wdata_d;
      sel_q   <= sel_d;
      we_q    <= we_d;
      ack_q   <= ack_d;
      err_q   <= err_d;
      rdata_q <= rdata_d;
      irq_q   <= irq_d;
    end
  end

  wb_cfg_regbank #(
    .NUM_REGS (pNUM_REGS),
    .IDX_W    (IDX_W)
  ) u_regbank (
    .clk       (wb_clk),
    .rst       (wb_rst),
    .wr_en     (commit && we_q && hit),
    .cnt_inc   (commit && we_q && (hit || !ERR_EN)),
    .idx       (idx),
    .sel       (sel_q),
    .wdata     (wdata_q),
    .regs_flat (cfg_out),
    .rd_data   (rd_data)
  );

  assign wbs_ack   = ack_q;
  assign wbs_rdata = rdata_q;
  assign irq_o     = irq_q;
`ifdef WB_CFG_ERR_EN
  assign wbs_err   = err_q;
`else
  logic unused_err;
  assign unused_err = err_q;
`endif

endmodule

// File: tb/tb_wb_cfg_responder.sv
// Bench for wb_cfg_responder: directed plan steps plus random traffic against an array model.
module tb_wb_cfg_responder;

  localparam logic [31:0] BASE  = 32'h3000_3000;
  localparam logic [31:0] MASK  = 32'hFFFF_FFE0;
  localparam int          NR    = 8;
  localparam int          WAITC = 2;
`ifdef WB_CFG_ERR_EN
  localparam bit ERR_EN = 1'b1;
`else
  localparam bit ERR_EN = 1'b0;
`endif

  logic          wb_clk = 1'b0;
  logic          wb_rst;
  logic [31:0]   wbs_adr, wbs_wdata;
  logic [3:0]    wbs_sel;
  logic          wbs_cyc, wbs_stb, wbs_we;

  logic          ack, irq, err;
  logic [31:0]   rdata;
  logic [32*NR-1:0] cfg;
  logic          ack0, irq0, err0;
  logic [31:0]   rdata0;
  logic [32*NR-1:0] cfg0;

  always #5 wb_clk = ~wb_clk;

  wb_cfg_responder #(.pADDR_BASE(BASE), .pADDR_MASK(MASK), .pNUM_REGS(NR), .pWAIT_CYCLES(WAITC)) dut (
    .wb_clk(wb_clk), .wb_rst(wb_rst), .wbs_adr(wbs_adr), .wbs_wdata(wbs_wdata), .wbs_sel(wbs_sel),
    .wbs_cyc(wbs_cyc), .wbs_stb(wbs_stb), .wbs_we(wbs_we), .wbs_ack(ack),
`ifdef WB_CFG_ERR_EN
    .wbs_err(err),
`endif
    .wbs_rdata(rdata), .cfg_out(cfg), .irq_o(irq));

  // Zero-wait instance on the same bus; only its ack latency and write are examined.
  wb_cfg_responder #(.pADDR_BASE(BASE), .pADDR_MASK(MASK), .pNUM_REGS(NR), .pWAIT_CYCLES(0)) dut0 (
    .wb_clk(wb_clk), .wb_rst(wb_rst), .wbs_adr(wbs_adr), .wbs_wdata(wbs_wdata), .wbs_sel(wbs_sel),
    .wbs_cyc(wbs_cyc), .wbs_stb(wbs_stb), .wbs_we(wbs_we), .wbs_ack(ack0),
`ifdef WB_CFG_ERR_EN
    .wbs_err(err0),
`endif
    .wbs_rdata(rdata0), .cfg_out(cfg0), .irq_o(irq0));

`ifndef WB_CFG_ERR_EN
  assign err  = 1'b0;
  assign err0 = 1'b0;
`endif

  int total = 0;
  int bad   = 0;
  logic [31:0] mregs [NR];

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [255:0] mimg();
    logic [255:0] img;
    for (int i = 0; i < NR; i++) img[32*i +: 32] = mregs[i];
    return img;
  endfunction

  task automatic model_clear();
    for (int i = 0; i < NR; i++) mregs[i] = '0;
  endtask

  // Applies one completed transfer to the model and returns the expected response.
  task automatic model_xfer(input logic [31:0] adr, input logic we, input logic [3:0] sel,
                            input logic [31:0] wd, output logic [31:0] erd,
                            output logic eirq, output logic eerr);
    logic hit;
    int   idx;
    hit  = ((adr & MASK) == BASE);
    idx  = int'(adr[4:2]);
    eerr = ERR_EN && !hit;
    erd  = (!we && hit) ? mregs[idx] : 32'd0;
    eirq = we && hit && (idx == 0) && sel[0] && wd[0];
    if (we && (hit || !ERR_EN)) begin
      if (hit && idx != NR - 1)
        for (int b = 0; b < 4; b++)
          if (sel[b]) mregs[idx][8*b +: 8] = wd[8*b +: 8];
      mregs[NR-1] = mregs[NR-1] + 32'd1;
    end
  endtask

  task automatic xfer(input logic [31:0] adr, input logic we, input logic [3:0] sel, input logic [31:0] wd);
    logic [31:0] erd;
    logic eirq, eerr, got;
    int k;
    model_xfer(adr, we, sel, wd, erd, eirq, eerr);
    @(negedge wb_clk);
    wbs_adr = adr; wbs_we = we; wbs_sel = sel; wbs_wdata = wd;
    wbs_cyc = 1'b1; wbs_stb = 1'b1;
    @(posedge wb_clk);
    k = 0; got = 1'b0;
    while (!got && k < 20) begin
      @(posedge wb_clk); #1;
      k++;
      got = ack | err;
    end
    chk("latency", 256'(k), 256'(WAITC + 1));
    chk("resp_kind", 256'({ack, err}), 256'({!eerr, eerr}));
    chk("rdata", 256'(rdata), 256'(erd));
    chk("irq", 256'(irq), 256'(eirq));
    chk("cfg_out", cfg, mimg());
    wbs_cyc = 1'b0; wbs_stb = 1'b0; wbs_we = 1'b0;
    @(posedge wb_clk); #1;
    chk("resp_fall", 256'({ack, err}), 256'(0));
    chk("rdata_fall", 256'(rdata), 256'(0));
    chk("irq_fall", 256'(irq), 256'(0));
  endtask

  initial begin
    logic [31:0] a;
    logic seen;
    model_clear();
    wb_rst = 1'b1;
    wbs_adr = '0; wbs_wdata = '0; wbs_sel = '0; wbs_cyc = 1'b0; wbs_stb = 1'b0; wbs_we = 1'b0;
    repeat (2) @(posedge wb_clk);
    #1;
    chk("rst_ack", 256'({ack, err, irq}), 256'(0));
    chk("rst_rdata", 256'(rdata), 256'(0));
    chk("rst_cfg", cfg, 256'(0));
    @(negedge wb_clk); wb_rst = 1'b0;
    repeat (2) @(negedge wb_clk);

    // Reg0 writes with irq bit set.
    xfer(BASE, 1'b1, 4'b0001, 32'h0000_0001);
    chk("reg0_a", 256'(cfg[31:0]), 256'(32'h1));
    chk("cnt_a", 256'(cfg[32*7 +: 32]), 256'(32'd1));
    xfer(BASE, 1'b1, 4'b0001, 32'h0000_0003);
    chk("reg0_b", 256'(cfg[31:0]), 256'(32'h3));
    chk("cnt_b", 256'(cfg[32*7 +: 32]), 256'(32'd2));

    // Byte lanes.
    xfer(BASE + 32'h4, 1'b1, 4'b0101, 32'hAABB_CCDD);
    chk("reg1_lanes", 256'(cfg[63:32]), 256'(32'h00BB_00DD));
    xfer(BASE + 32'h4, 1'b0, 4'b1111, 32'h0);

    // Abort in WAIT by dropping stb one cycle after the request.
    @(negedge wb_clk);
    wbs_adr = BASE + 32'h8; wbs_we = 1'b1; wbs_sel = 4'hF; wbs_wdata = 32'hFFFF_FFFF;
    wbs_cyc = 1'b1; wbs_stb = 1'b1;
    @(posedge wb_clk);
    @(negedge wb_clk); wbs_stb = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(posedge wb_clk); #1;
      seen = seen | ack | err;
    end
    wbs_cyc = 1'b0; wbs_we = 1'b0;
    chk("abort_noack", 256'(seen), 256'(0));
    chk("abort_cfg", cfg, mimg());

    // Decode miss.
    xfer(32'h3000_4000, 1'b1, 4'hF, 32'hDEAD_BEEF);
    xfer(32'h3000_4000, 1'b0, 4'hF, 32'h0);

    // Random traffic, including unaligned low bits and misses.
    for (int n = 0; n < 40; n++) begin
      if ($urandom_range(0, 7) == 0) a = BASE + 32'h1000 + 32'($urandom_range(0, 31));
      else a = BASE + 32'($urandom_range(0, 31));
      xfer(a, 1'($urandom_range(0, 1)), 4'($urandom), $urandom);
      repeat ($urandom_range(0, 2)) @(negedge wb_clk);
    end

    // Asynchronous reset while the main instance sits in WAIT.
    @(negedge wb_clk);
    wbs_adr = BASE + 32'hC; wbs_we = 1'b1; wbs_sel = 4'hF; wbs_wdata = 32'h1234_5678;
    wbs_cyc = 1'b1; wbs_stb = 1'b1;
    @(posedge wb_clk);
    @(posedge wb_clk);
    #2 wb_rst = 1'b1;
    #1;
    chk("arst_out", 256'({ack, err, irq}), 256'(0));
    chk("arst_rdata", 256'(rdata), 256'(0));
    chk("arst_cfg", cfg, 256'(0));
    wbs_cyc = 1'b0; wbs_stb = 1'b0; wbs_we = 1'b0;
    model_clear();
    @(negedge wb_clk); wb_rst = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(posedge wb_clk); #1;
      seen = seen | ack | err;
    end
    chk("arst_noack", 256'(seen), 256'(0));
    chk("arst_cfg_after", cfg, mimg());

    // Zero-wait instance acks on the first edge after sampling.
    @(negedge wb_clk);
    wbs_adr = BASE + 32'h4; wbs_we = 1'b1; wbs_sel = 4'b0001; wbs_wdata = 32'h0000_0055;
    wbs_cyc = 1'b1; wbs_stb = 1'b1;
    @(posedge wb_clk);
    @(posedge wb_clk); #1;
    chk("w0_ack", 256'(ack0), 256'(1));
    chk("w0_main_noack", 256'(ack), 256'(0));
    chk("w0_cfg", cfg0, {32'd1, 160'd0, 32'h55, 32'd0});
    wbs_cyc = 1'b0; wbs_stb = 1'b0; wbs_we = 1'b0;
    @(posedge wb_clk); #1;
    chk("w0_ack_fall", 256'(ack0), 256'(0));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
